// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM host sequencer and the EEPROM_WR byte controller.
package eeprom_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  localparam logic YES = 1'b1;
  localparam logic NO  = 1'b0;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_ISSUE    = 5'b00010,
    ST_WAIT_ACK = 5'b00100,
    ST_RESP     = 5'b01000,
    ST_GAP      = 5'b10000
  } seq_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eeprom_seq_timer.sv
// Loadable down-counter; done is high while the count sits at zero, and it never wraps.
module eeprom_seq_timer #(
  parameter int W = 12
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET)                 cnt <= '0;
    else if (clr)              cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/eeprom_host_seq.sv
// Host command sequencer: one byte read/write in flight, ACK timeout, post-write tWR gap.
module eeprom_host_seq
  import eeprom_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 4096,
  parameter int WR_GAP  = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              WR,
  output logic              RD,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA,
  input  logic              ACK
);

  localparam int TW = $clog2(max2(TIMEOUT, WR_GAP) + 1);
  localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LD = TW'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic HAS_GAP = (WR_GAP > 0);

  seq_state_e        state;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              tmr_clr, tmr_en, tmr_done;
  logic [TW-1:0]     tmr_ld;

  // Timer is reloaded on the edge that enters WAIT_ACK or GAP, so count==0 marks the last cycle.
  always_comb begin
    tmr_clr = NO;
    tmr_ld  = '0;
    if (state == ST_ISSUE) begin
      tmr_clr = YES;
      tmr_ld  = TO_LD;
    end else if (state == ST_RESP && rsp_ready && !rw_q && HAS_GAP) begin
      tmr_clr = YES;
      tmr_ld  = GAP_LD;
    end
  end

  assign tmr_en = (state == ST_WAIT_ACK) || (state == ST_GAP);

  eeprom_seq_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr      (tmr_clr),
    .load_val (tmr_ld),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  assign DATA = WR ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cmd_ready <= NO;
      rsp_valid <= NO;
      rsp_rdata <= '0;
      rsp_err   <= NO;
      WR        <= NO;
      RD        <= NO;
      ADDR      <= '0;
      rw_q      <= NO;
      wdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= YES;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= NO;
            rw_q      <= cmd_rw;
            ADDR      <= cmd_addr;
            wdata_q   <= cmd_wdata;
            WR        <= !cmd_rw;
            RD        <= cmd_rw;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          // ACK takes priority over a timeout landing in the same cycle.
          if (ACK) begin
            WR        <= NO;
            RD        <= NO;
            rsp_valid <= YES;
            rsp_err   <= NO;
            rsp_rdata <= rw_q ? DATA : '0;
            state     <= ST_RESP;
          end else if (tmr_done) begin
            WR        <= NO;
            RD        <= NO;
            rsp_valid <= YES;
            rsp_err   <= YES;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= NO;
            if (!rw_q && HAS_GAP) begin
              state <= ST_GAP;
            end else begin
              state     <= ST_IDLE;
              cmd_ready <= YES;
            end
          end
        end
        ST_GAP: begin
          if (tmr_done) begin
            state     <= ST_IDLE;
            cmd_ready <= YES;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_host_seq.sv
// Directed bench for eeprom_host_seq: per-transaction expectations checked every cycle.
module tb_eeprom_host_seq;

  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int TO  = 32;
  localparam int GAP = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          cmd_valid, cmd_ready, cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          WR, RD, ACK;
  logic [AW-1:0] ADDR;
  wire  [DW-1:0] DATA;
  logic [DW-1:0] tb_data;
  logic          tb_drv;

  assign DATA = tb_drv ? tb_data : {DW{1'bz}};

  always #5 CLK = ~CLK;

  eeprom_host_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .WR_GAP(GAP)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA), .ACK(ACK)
  );

  // expected outputs for the current cycle
  logic          chk_en, chk_addr, e_pay;
  logic          e_rdy, e_wr, e_rd, e_rv, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rdata;
  logic [DW-1:0] zbus;

  logic  pin_req;
  string pin_name;
  int    pin_act, pin_exp;

  int n_run = 0, n_fail = 0;
  int wr_total = 0, nrdy_total = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (WR === 1'b1)        wr_total++;
    if (cmd_ready === 1'b0) nrdy_total++;
    if (chk_en) begin
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, e_rdy});
      chk("WR", {31'b0, WR}, {31'b0, e_wr});
      chk("RD", {31'b0, RD}, {31'b0, e_rd});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
      if (chk_addr) chk("ADDR", {21'b0, ADDR}, {21'b0, e_addr});
      if (!tb_drv)  chk("DATA", {24'b0, DATA}, {24'b0, (e_wr ? e_wd : zbus)});
      if (e_pay) begin
        chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, e_rdata});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
      end
    end
    if (pin_req) chk(pin_name, pin_act, pin_exp);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pin(input string nm, input int a, input int e);
    pin_name = nm; pin_act = a; pin_exp = e; pin_req = 1'b1;
    @(negedge CLK);
    #1;
    pin_req = 1'b0;
  endtask

  task automatic exp_reset();
    e_rdy = 0; e_wr = 0; e_rd = 0; e_rv = 0;
    chk_addr = 1; e_addr = '0;
    e_pay = 1; e_rdata = '0; e_err = 0;
  endtask

  task automatic exp_idle();
    e_rdy = 1; e_wr = 0; e_rd = 0; e_rv = 0; chk_addr = 0; e_pay = 0;
  endtask

  // ack_at: cycle index (0 = first WR/RD-high cycle) in which ACK pulses; -1 = never.
  task automatic run_cmd(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int ack_at, input logic [DW-1:0] rdv, input int hold,
                         output int wr_cyc, output int gap_cyc);
    int   w0, n0;
    logic acked;
    w0 = wr_total;
    cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_wdata = wd;
    step();
    cmd_valid = 0; cmd_addr = ~a; cmd_wdata = ~wd;
    e_rdy = 0; e_wr = !rw; e_rd = rw; chk_addr = 1; e_addr = a; e_wd = wd; e_rv = 0; e_pay = 0;
    acked = 0;
    for (int k = 0; k <= TO; k++) begin
      ACK = (k == ack_at);
      if (k == ack_at && rw) begin tb_drv = 1; tb_data = rdv; end
      acked = (k == ack_at) && (k >= 1);
      step();
      ACK = 0; tb_drv = 0;
      if (acked || k == TO) break;
    end
    e_wr = 0; e_rd = 0; chk_addr = 0;
    e_rv = 1; e_pay = 1; e_err = !acked;
    e_rdata = (acked && rw) ? rdv : '0;
    wr_cyc = wr_total - w0;
    rsp_ready = 0;
    repeat (hold) step();
    rsp_ready = 1;
    step();
    rsp_ready = 0; e_rv = 0; e_pay = 0;
    n0 = nrdy_total;
    if (!rw && GAP > 0) begin
      repeat (GAP - 1) step();
      step();
    end
    e_rdy = 1;
    step();
    gap_cyc = nrdy_total - n0;
  endtask

  int wc, gc;

  initial begin
    zbus = {DW{1'bz}};
    cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; ACK = 0; tb_drv = 0; tb_data = '0;
    chk_en = 0; pin_req = 0; pin_name = ""; pin_act = 0; pin_exp = 0;
    e_wd = '0;
    exp_reset();
    RESET = 1;
    step();
    chk_en = 1;
    step();
    RESET = 0;
    step();
    exp_idle();
    step();

    // write 0x5A @ 0x123, ACK 20 cycles after WR rise
    run_cmd(0, 11'h123, 8'h5A, 20, 8'h00, 0, wc, gc);
    pin("write_wr_high_cycles", wc, 21);
    pin("write_gap_cycles", gc, 8);

    // read 0x123 returning 0xA5, no gap
    run_cmd(1, 11'h123, 8'h00, 5, 8'hA5, 0, wc, gc);
    pin("read_wr_high_cycles", wc, 0);
    pin("read_gap_cycles", gc, 0);

    // write with no ACK: timeout
    run_cmd(0, 11'h7FF, 8'hFF, -1, 8'h00, 0, wc, gc);
    pin("timeout_wr_high_cycles", wc, 33);
    pin("timeout_gap_cycles", gc, 8);

    // read with host back-pressure for 10 cycles
    run_cmd(1, 11'h000, 8'h00, 3, 8'h3C, 10, wc, gc);

    // spurious ACK while idle
    ACK = 1;
    step();
    ACK = 0;
    repeat (3) step();

    // ACK on the timeout cycle wins
    run_cmd(0, 11'h055, 8'h81, TO, 8'h00, 0, wc, gc);
    pin("coincident_wr_high_cycles", wc, 33);

    // ACK during ISSUE is ignored, so this read times out
    run_cmd(1, 11'h2AA, 8'h00, 0, 8'h99, 2, wc, gc);

    // RESET during WAIT_ACK drops WR and discards the command
    cmd_valid = 1; cmd_rw = 0; cmd_addr = 11'h321; cmd_wdata = 8'hC3;
    step();
    cmd_valid = 0;
    e_rdy = 0; e_wr = 1; e_rd = 0; chk_addr = 1; e_addr = 11'h321; e_wd = 8'hC3;
    repeat (5) step();
    RESET = 1;
    step();
    exp_reset();
    RESET = 0;
    step();
    exp_idle();
    repeat (4) step();

    run_cmd(0, 11'h321, 8'hC3, 2, 8'h00, 0, wc, gc);
    pin("post_reset_wr_high_cycles", wc, 3);

    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
